// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the dual-read / single-write register file.
// The master drives commands; the slave returns busy and registered read data.
interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int BE_W = DATA_W / 8;

  logic              clr;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   wbe;
  logic              re0;
  logic [ADDR_W-1:0] raddr0;
  logic [DATA_W-1:0] rdata0;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output clr, we, waddr, wdata, wbe, re0, raddr0, re1, raddr1,
    input  busy, rdata0, rdata1
  );

  modport slave (
    input  clr, we, waddr, wdata, wbe, re0, raddr0, re1, raddr1,
    output busy, rdata0, rdata1
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file: one byte-enabled write port, two registered read ports with
// write-through bypass, and a clear sequencer that fills every entry with INIT_VAL.
module regfile_2r1w #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  regfile_2r1w_if.slave bus
);
  localparam int                BE_W  = DATA_W / 8;
  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] merged;

  // Word the write port would leave behind: enabled bytes from wdata, rest from the array.
  always_comb begin
    merged = mem_q[bus.waddr];
    for (int k = 0; k < BE_W; k++) begin
      if (bus.wbe[k]) merged[8*k +: 8] = bus.wdata[8*k +: 8];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = INIT_VAL;

    case (state_q)
      CLEAR: begin
        // User commands are ignored here; only the sequencer touches the array.
        mem_we = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        if (bus.we && (|bus.wbe)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.waddr;
          mem_wdata = merged;
        end
        // Same-cycle read of the write address returns the post-write word.
        if (bus.re0) rdata0_d = (bus.we && bus.raddr0 == bus.waddr) ? merged : mem_q[bus.raddr0];
        if (bus.re1) rdata1_d = (bus.we && bus.raddr1 == bus.waddr) ? merged : mem_q[bus.raddr1];
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // NOTE: the array has no reset; the clear sequencer gives it a known value instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.busy   = (state_q == CLEAR);
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a vector table for IDLE-mode traffic plus
// hand-written clear, clr-during-clear and reset-during-clear sequences.
module tb_regfile_2r1w;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 3;
  localparam logic [15:0] INIT   = 16'hA5A5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic        re0;
    logic [2:0]  ra0;
    logic        re1;
    logic [2:0]  ra1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic we, input logic [2:0] waddr, input logic [15:0] wdata,
                              input logic [1:0] wbe, input logic re0, input logic [2:0] ra0,
                              input logic re1, input logic [2:0] ra1,
                              input logic [15:0] exp0, input logic [15:0] exp1);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.wbe = wbe;
    v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
    v.exp0 = exp0; v.exp1 = exp1;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wbe = '0;
    bus.re0 = 1'b0; bus.raddr0 = '0; bus.re1 = 1'b0; bus.raddr1 = '0;
  endtask

  // busy must be high after edges 1..7 of a clear window and low after edge 8.
  task automatic check_clear_window(input string tag);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("%s_busy_e%0d", tag, e), {15'b0, bus.busy}, {15'b0, (e < 8)});
    end
  endtask

  task automatic read_all_init(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.re0 = 1'b1; bus.raddr0 = 3'(a);
      bus.re1 = 1'b1; bus.raddr1 = 3'(7 - a);
      tick();
      check($sformatf("%s_r0_a%0d", tag, a), bus.rdata0, INIT);
      check($sformatf("%s_r1_a%0d", tag, 7 - a), bus.rdata1, INIT);
    end
    idle_inputs();
  endtask

  initial begin
    // Vector table: IDLE-mode traffic, one vector per clock.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b1, 3'(7 - i), INIT, INIT));
    vecs.push_back(mk(1'b1, 3'd3, 16'h1234, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, INIT, INIT));
    vecs.push_back(mk(1'b1, 3'd3, 16'hFF00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, INIT, INIT));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b1, 3'd3, 16'h1200, 16'h1200));
    vecs.push_back(mk(1'b1, 3'd5, 16'hFFFF, 2'b00, 1'b1, 3'd5, 1'b1, 3'd3, INIT, 16'h1200));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd5, 1'b1, 3'd5, INIT, INIT));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 3'(i), 16'(i * 16 + 5), 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, INIT, INIT));
    vecs.push_back(mk(1'b1, 3'd2, 16'hBEEF, 2'b11, 1'b1, 3'd2, 1'b1, 3'd6, 16'hBEEF, 16'h0065));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd6, 1'b1, 3'd2, 16'h0065, 16'hBEEF));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd1, 1'b0, 3'd3, 16'h0065, 16'hBEEF));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd7, 1'b0, 3'd0, 16'h0065, 16'hBEEF));
    vecs.push_back(mk(1'b1, 3'd4, 16'h1111, 2'b11, 1'b0, 3'd4, 1'b0, 3'd4, 16'h0065, 16'hBEEF));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd1, 1'b1, 3'd1, 16'h0015, 16'h0015));
    vecs.push_back(mk(1'b1, 3'd7, 16'hAB00, 2'b10, 1'b1, 3'd7, 1'b1, 3'd4, 16'hAB75, 16'h1111));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd7, 1'b1, 3'd0, 16'hAB75, 16'h0005));

    // Reset state, then the power-on clear window.
    rst = 1'b1;
    idle_inputs();
    #3;
    check("rst_busy", {15'b0, bus.busy}, 16'h1);
    check("rst_rdata0", bus.rdata0, 16'h0);
    check("rst_rdata1", bus.rdata1, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    check_clear_window("init");
    read_all_init("init");

    foreach (vecs[i]) begin
      bus.we = vecs[i].we; bus.waddr = vecs[i].waddr; bus.wdata = vecs[i].wdata; bus.wbe = vecs[i].wbe;
      bus.re0 = vecs[i].re0; bus.raddr0 = vecs[i].ra0;
      bus.re1 = vecs[i].re1; bus.raddr1 = vecs[i].ra1;
      tick();
      check($sformatf("vec%0d_rdata0", i), bus.rdata0, vecs[i].exp0);
      check($sformatf("vec%0d_rdata1", i), bus.rdata1, vecs[i].exp1);
    end
    idle_inputs();

    // clr in IDLE together with a write and bypassed read: both still accepted.
    bus.clr = 1'b1;
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 16'h7777; bus.wbe = 2'b11;
    bus.re0 = 1'b1; bus.raddr0 = 3'd0;
    tick();
    check("clr_busy_e0", {15'b0, bus.busy}, 16'h1);
    check("clr_bypass_rdata0", bus.rdata0, 16'h7777);
    check("clr_hold_rdata1", bus.rdata1, 16'h0005);
    idle_inputs();

    // During CLEAR: re-asserted clr, writes and reads must all be ignored.
    for (int e = 1; e <= 8; e++) begin
      bus.clr = (e == 3 || e == 4);
      bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 16'h0BAD; bus.wbe = 2'b11;
      bus.re0 = 1'b1; bus.raddr0 = 3'(e);
      bus.re1 = 1'b1; bus.raddr1 = 3'd0;
      tick();
      check($sformatf("clr_busy_e%0d", e), {15'b0, bus.busy}, {15'b0, (e < 8)});
      if (e < 8) begin
        check($sformatf("clr_hold0_e%0d", e), bus.rdata0, 16'h7777);
        check($sformatf("clr_hold1_e%0d", e), bus.rdata1, 16'h0005);
      end
      if (e == 7) idle_inputs();
    end
    idle_inputs();
    read_all_init("postclr");

    // Reset four cycles into a clear: outputs drop at once, then a full window again.
    bus.clr = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();
    check("midclr_busy", {15'b0, bus.busy}, 16'h1);
    rst = 1'b1;
    #1;
    check("midrst_rdata0", bus.rdata0, 16'h0);
    check("midrst_rdata1", bus.rdata1, 16'h0);
    check("midrst_busy", {15'b0, bus.busy}, 16'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_clear_window("rerst");
    read_all_init("rerst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
